pwm_bank: RTL and testbench
===========================

# pwm_bank

Multi-channel PWM generator and the parametrised successor of the single-channel PWM driver. `CHANNELS` outputs share one period counter, so all channels stay phase-locked. Period and duty values pass through a valid/ready load port into shadow registers, and take effect only at a period boundary, which keeps the outputs glitch-free. It sits between the register/command logic and the actuator pins.

## Interface
- `CHANNELS`, 4: number of PWM outputs (1..32).
- `COUNTER_BITS`, 16: width of the counter, `cycle` and each duty.
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: run the counter. Low forces idle.
- `center`, in, 1: mode select, 1 = center-aligned. Ignored unless `PWM_BANK_CENTER_EN` is defined.
- `cycle`, in, `COUNTER_BITS`: requested period in counts.
- `duty`, in, `CHANNELS*COUNTER_BITS`: requested per-channel high counts. Channel i is `duty[i*COUNTER_BITS +: COUNTER_BITS]`.
- `load_valid`, in, 1: `cycle`/`duty`/`center` are valid.
- `load_ready`, out, 1: the shadow register is free.
- `pwm`, out, `CHANNELS`: registered PWM outputs.
- `period_start`, out, 1: one-clock pulse at the first count of each period.

## Operation
- **Active set.** The block holds one active set (`cycle_a`, `duty_a[i]`, `center_a`), which drives the outputs. It also holds one pending set plus a pending flag.
- **Load acceptance.** A load is accepted on a `clk` edge with `load_valid && load_ready`.
  - The pending set is captured and the pending flag is set.
  - `load_ready` = !pending flag.
- **Pending transfer.** Pending moves to active:
  - at the period boundary, i.e. the edge where the counter returns to 0, or
  - on the next edge if `enable` is low.
  - The pending flag then clears.
  - A load accepted on a boundary edge waits for the following boundary.
- **Edge mode (default).**
  - Counter runs 0..`cycle_a`-1 and wraps to 0.
  - `pwm[i]` is high when `counter >= cycle_a - duty_a[i]`, i.e. right-aligned, high for the last `duty_a[i]` counts.
- **Duty saturation.** A duty of `cycle_a` or more gives a constant high output. A duty of 0 gives a constant low output. The subtraction is unsigned and uses a saturated duty, so it never underflows.
- **Zero period.** `cycle_a` == 0: the counter holds at 0, all `pwm` are 0, and `period_start` stays 0.
- **Disable.** `enable` low: the counter is set to 0 and the direction to up; `pwm` = 0 and `period_start` = 0.
  - Re-enabling starts a fresh period at count 0.
- **Reset values.** `reset` low (asynchronous):
  - counter 0, direction up
  - active and pending sets 0, pending flag 0
  - `pwm` = 0, `period_start` = 0, `load_ready` = 1

## Timing
- **Output latency.** `pwm` and `period_start` are registered and lag the counter compare by one clock.
- **`period_start` pulse.** Asserts for exactly one clock, in the same cycle that `pwm` reflects count 0 of the new period.
- **Update timing.** New values govern the first full period after a boundary. `load_ready` returns high on the clock after the transfer.
- **Ignored loads.** While `load_ready` = 0, `load_valid` is ignored and no data is dropped silently into the active set.
- **`enable` deassert.** Outputs go to 0 on the next clock edge.
- **Reset deassert.** The first count-0 cycle occurs on the first edge with `enable` = 1 and `cycle_a` != 0.

## Configuration
- **`PWM_BANK_CENTER_EN` defined.** `center_a` = 1 selects up/down counting:
  - The counter runs 0..`cycle_a`-1, then `cycle_a`-1..0. Both end values are held for 2 clocks, so the period is 2*`cycle_a` clocks.
  - `pwm[i]` uses the same compare, giving a pulse of 2*`duty_a[i]` clocks centered on the top of the count.
  - The boundary and `period_start` occur only at the bottom, when the up count restarts.
- **`PWM_BANK_CENTER_EN` undefined.** The `center` input is ignored, `center_a` is tied to 0, and no direction logic exists.

## Test plan
All scenarios use `CHANNELS`=2 and `COUNTER_BITS`=8.
1. **Reset.** Assert `reset` low for 3 clocks -> `pwm`=00, `period_start`=0, `load_ready`=1 throughout.
2. **Basic edge mode.** Load `cycle`=10, `duty`={3,0} with `enable`=0, then set `enable`=1 -> ch0 is high for counts 7..9 of every 10 clocks, ch1 is constantly 0, and `period_start` pulses every 10 clocks.
3. **Saturation and zero period.**
   - `cycle`=10 with duty={10,200} -> both channels constantly 1.
   - Then load `cycle`=0 -> both channels 0 from the next boundary, and `period_start` stays silent.
4. **Mid-period load.** With `cycle`=10, ch0 `duty`=3, load `duty`=7 at count 4 -> the current period keeps 3 high clocks and the next period has 7.
   - `load_ready` is low from count 5 until 1 clock after the boundary.
   - A second `load_valid` during that window does not alter the active or pending set.
5. **Reset mid-period.** Assert `reset` at count 5 -> `pwm`=00 immediately without waiting for a clock, and the pending set is discarded.
   - After release with `enable`=1, nothing runs until a new load, because `cycle_a`=0.
6. **Center mode.** With `PWM_BANK_CENTER_EN` defined, set `center`=1, `cycle`=10, `duty`=3 -> 20-clock period with ch0 high for 6 consecutive clocks (counts 7,8,9,9,8,7) and `period_start` once per 20 clocks.

Source files
------------

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel phase-locked PWM generator with shadowed period/duty load port
// Optional feature macro: PWM_BANK_CENTER_EN (center-aligned up/down counting).
// Ports:
//   clk_i           clock
//   reset_ni        asynchronous active-low reset
//   enable_i        run the shared counter; low forces all outputs idle
//   center_i        center-aligned mode request (used only with PWM_BANK_CENTER_EN)
//   cycle_i         requested period in counts
//   duty_i          per-channel high counts, channel i at [i*COUNTER_BITS +: COUNTER_BITS]
//   load_valid_i    cycle_i/duty_i/center_i are valid
//   load_ready_o    pending shadow set is free
//   pwm_o           registered PWM outputs
//   period_start_o  one-clock pulse with the output of count 0 of each period
module pwm_bank #(
    parameter int CHANNELS     = 4,
    parameter int COUNTER_BITS = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic                             enable_i,
    input  logic                             center_i,
    input  logic [COUNTER_BITS-1:0]          cycle_i,
    input  logic [CHANNELS*COUNTER_BITS-1:0] duty_i,
    input  logic                             load_valid_i,
    output logic                             load_ready_o,
    output logic [CHANNELS-1:0]              pwm_o,
    output logic                             period_start_o
);
    typedef logic [COUNTER_BITS-1:0] cnt_t;
    cnt_t cnt_q, cnt_d, cycle_a_q, cycle_p_q, top;
    cnt_t duty_a_q [CHANNELS];
    cnt_t duty_p_q [CHANNELS];
    logic pend_q, bound, xfer, accept, zero, up, ps_d;
    logic [CHANNELS-1:0] pwm_d;
`ifdef PWM_BANK_CENTER_EN
    logic dir_q, dir_d, center_a_q, center_p_q;
    assign up = !dir_q;
`else
    logic unused_center;
    assign unused_center = center_i;
    assign up = 1'b1;
`endif
    assign zero = cycle_a_q == '0;
    assign top = cycle_a_q - cnt_t'(1);
    assign accept = load_valid_i && !pend_q;
    assign xfer = pend_q && (!enable_i || bound);
    assign load_ready_o = !pend_q;
    // bound marks the edge on which the counter re-enters count 0 of a new period;
    // a zero period counts as a boundary every clock so a new load can still land.
    always_comb begin
        cnt_d = cnt_q;
        bound = 1'b0;
`ifdef PWM_BANK_CENTER_EN
        dir_d = 1'b0;
`endif
        if (!enable_i) begin
            cnt_d = '0;
        end else if (zero) begin
            cnt_d = '0;
            bound = 1'b1;
`ifdef PWM_BANK_CENTER_EN
        end else if (center_a_q && !dir_q) begin
            dir_d = cnt_q >= top;
            cnt_d = dir_d ? cnt_q : cnt_q + cnt_t'(1);
        end else if (center_a_q) begin
            bound = cnt_q == '0;
            dir_d = !bound;
            cnt_d = bound ? cnt_q : cnt_q - cnt_t'(1);
`endif
        end else begin
            bound = cnt_q >= top;
            cnt_d = bound ? '0 : cnt_q + cnt_t'(1);
        end
    end
    // Duty is clamped to the period before subtracting, so the threshold never wraps.
    always_comb begin
        pwm_d = '0;
        ps_d = enable_i && !zero && up && cnt_q == '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable_i && !zero &&
                       cnt_q >= cycle_a_q - (duty_a_q[i] >= cycle_a_q ? cycle_a_q : duty_a_q[i]);
        end
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q          <= '0;
            cycle_a_q      <= '0;
            cycle_p_q      <= '0;
            pend_q         <= 1'b0;
            pwm_o          <= '0;
            period_start_o <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_a_q[i] <= '0;
                duty_p_q[i] <= '0;
            end
        end else begin
            cnt_q          <= cnt_d;
            pwm_o          <= pwm_d;
            period_start_o <= ps_d;
            pend_q         <= accept || (pend_q && !xfer);
            if (accept) begin
                cycle_p_q <= cycle_i;
                for (int i = 0; i < CHANNELS; i++) begin
                    duty_p_q[i] <= duty_i[i*COUNTER_BITS +: COUNTER_BITS];
                end
            end
            if (xfer) begin
                cycle_a_q <= cycle_p_q;
                for (int i = 0; i < CHANNELS; i++) begin
                    duty_a_q[i] <= duty_p_q[i];
                end
            end
        end
    end
`ifdef PWM_BANK_CENTER_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dir_q      <= 1'b0;
            center_a_q <= 1'b0;
            center_p_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
            if (accept) center_p_q <= center_i;
            if (xfer) center_a_q <= center_p_q;
        end
    end
`endif
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: scoreboard bench for pwm_bank with CHANNELS=2, COUNTER_BITS=8
module tb_pwm_bank;
    logic        clk = 1'b0;
    logic        reset_ni = 1'b1;
    logic        enable = 1'b0;
    logic        center = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  cycle = '0;
    logic [15:0] duty = '0;
    logic        load_ready, period_start;
    logic [1:0]  pwm;
    logic [3:0]  exp_q [$];
    string       name_q [$];
    logic [3:0]  e;
    string       nm;
    int          n_chk = 0;
    int          n_fail = 0;
    event        mon_ev;

    always #5 clk = ~clk;

    pwm_bank #(.CHANNELS(2), .COUNTER_BITS(8)) dut (
        .clk_i          (clk),
        .reset_ni       (reset_ni),
        .enable_i       (enable),
        .center_i       (center),
        .cycle_i        (cycle),
        .duty_i         (duty),
        .load_valid_i   (load_valid),
        .load_ready_o   (load_ready),
        .pwm_o          (pwm),
        .period_start_o (period_start)
    );

    task automatic push(input logic [1:0] p, input logic ps, input logic r, input string n);
        exp_q.push_back({p, ps, r});
        name_q.push_back(n);
    endtask

    // Expectation for the outputs right after the next rising edge.
    task automatic cyc(input logic [1:0] p, input logic ps, input logic r, input string n);
        @(posedge clk);
        #1;
        push(p, ps, r, n);
    endtask

    task automatic load(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1, input logic ctr);
        cycle = c;
        duty = {d1, d0};
        center = ctr;
        load_valid = 1'b1;
    endtask

    initial forever begin
        @(negedge clk or mon_ev);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            n_chk++;
            if ({pwm, period_start, load_ready} !== e) begin
                n_fail++;
                $display("FAIL %s: got pwm=%b ps=%b rdy=%b, expected pwm=%b ps=%b rdy=%b",
                         nm, pwm, period_start, load_ready, e[3:2], e[1], e[0]);
            end
        end
    end

    initial begin
        #2 reset_ni = 1'b0;
        repeat (3) cyc(2'b00, 1'b0, 1'b1, "reset");
        reset_ni = 1'b1;
        // Basic edge mode, loaded while idle
        load(10, 3, 0, 0);
        cyc(2'b00, 1'b0, 1'b0, "load_idle");
        load_valid = 1'b0;
        cyc(2'b00, 1'b0, 1'b1, "xfer_idle");
        enable = 1'b1;
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 10; k++) cyc({1'b0, k >= 7}, k == 0, 1'b1, "edge_basic");
        // Saturation, then zero period
        load(10, 10, 200, 0);
        for (int k = 0; k < 10; k++) begin
            cyc({1'b0, k >= 7}, k == 0, k == 9, "sat_pending");
            load_valid = 1'b0;
        end
        for (int k = 0; k < 10; k++) cyc(2'b11, k == 0, 1'b1, "sat_full");
        load(0, 10, 200, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(2'b11, k == 0, k == 9, "zero_pending");
            load_valid = 1'b0;
        end
        repeat (5) cyc(2'b00, 1'b0, 1'b1, "zero_period");
        // Mid-period load plus an ignored second load
        load(10, 3, 0, 0);
        cyc(2'b00, 1'b0, 1'b0, "mid_accept");
        load_valid = 1'b0;
        cyc(2'b00, 1'b0, 1'b1, "mid_xfer");
        for (int k = 0; k < 10; k++) begin
            if (k == 4) load(10, 7, 0, 0);
            if (k == 6) load(5, 1, 1, 0);
            cyc({1'b0, k >= 7}, k == 0, k < 4 || k == 9, "mid_old");
            load_valid = 1'b0;
        end
        for (int k = 0; k < 10; k++) cyc({1'b0, k >= 3}, k == 0, 1'b1, "mid_new");
        // Reset mid-period discards the pending set
        load(10, 9, 9, 0);
        for (int k = 0; k < 5; k++) begin
            cyc({1'b0, k >= 3}, k == 0, 1'b0, "rst_run");
            load_valid = 1'b0;
        end
        @(negedge clk);
        #2 reset_ni = 1'b0;
        #1 push(2'b00, 1'b0, 1'b1, "rst_async");
        ->mon_ev;
        repeat (2) cyc(2'b00, 1'b0, 1'b1, "rst_hold");
        reset_ni = 1'b1;
        repeat (5) cyc(2'b00, 1'b0, 1'b1, "rst_idle");
        // Enable deassert and restart
        load(4, 1, 4, 0);
        cyc(2'b00, 1'b0, 1'b0, "dis_accept");
        load_valid = 1'b0;
        cyc(2'b00, 1'b0, 1'b1, "dis_xfer");
        for (int k = 0; k < 6; k++) cyc({1'b1, (k % 4) >= 3}, (k % 4) == 0, 1'b1, "dis_run");
        enable = 1'b0;
        repeat (2) cyc(2'b00, 1'b0, 1'b1, "dis_off");
        enable = 1'b1;
        for (int k = 0; k < 4; k++) cyc({1'b1, k >= 3}, k == 0, 1'b1, "dis_restart");
        // Center request
        enable = 1'b0;
        load(10, 3, 0, 1);
        cyc(2'b00, 1'b0, 1'b0, "ctr_accept");
        load_valid = 1'b0;
        cyc(2'b00, 1'b0, 1'b1, "ctr_xfer");
        enable = 1'b1;
`ifdef PWM_BANK_CENTER_EN
        for (int j = 0; j < 40; j++) begin
            int c;
            c = j % 20;
            c = c < 10 ? c : 19 - c;
            cyc({1'b0, c >= 7}, (j % 20) == 0, 1'b1, "center");
        end
`else
        for (int j = 0; j < 20; j++) cyc({1'b0, (j % 10) >= 7}, (j % 10) == 0, 1'b1, "center_ignored");
`endif
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
